// File: rtl/mant_align_pkg.sv
// Shared constants and FSM state type for the FP adder mantissa alignment stage.
package mant_align_pkg;

    localparam int unsigned MANT_W    = 24;
    localparam int unsigned EXP_W     = 8;
    localparam int unsigned GRS_W     = 3;
    localparam int unsigned SHAMT_MAX = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/mant_align_if.sv
// Operand-in / aligned-result-out handshake bundle; the alignment stage is the slave.
interface mant_align_if #(
    parameter int unsigned MANT_W = mant_align_pkg::MANT_W,
    parameter int unsigned EXP_W  = mant_align_pkg::EXP_W
);
    logic                  in_valid;
    logic                  in_ready;
    logic [MANT_W-1:0]     m_a;
    logic [MANT_W-1:0]     m_b;
    logic [EXP_W-1:0]      e_a;
    logic [EXP_W-1:0]      e_b;
    logic [4:0]            shamt;
    logic                  sh_ab;
    logic                  out_valid;
    logic                  out_ready;
    logic [MANT_W+2:0]     ma_out;
    logic [MANT_W+2:0]     mb_out;
    logic [EXP_W-1:0]      e_out;

    modport slave (
        input  in_valid, m_a, m_b, e_a, e_b, shamt, sh_ab, out_ready,
        output in_ready, out_valid, ma_out, mb_out, e_out
    );

    modport master (
        output in_valid, m_a, m_b, e_a, e_b, shamt, sh_ab, out_ready,
        input  in_ready, out_valid, ma_out, mb_out, e_out
    );
endinterface

// File: rtl/mant_align_sticky_shr.sv
// One-step right shifter: bit 0 of the result collects every bit shifted out plus the old sticky.
module sticky_shr #(
    parameter int unsigned W  = 27,
    parameter int unsigned KW = 5
) (
    input  logic [W-1:0]  val_i,
    input  logic [KW-1:0] k_i,
    output logic [W-1:0]  val_o
);
    logic sticky;

    always_comb begin
        sticky = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (i <= 32'(k_i)) sticky = sticky | val_i[i];
        end
        val_o    = val_i >> k_i;
        val_o[0] = sticky;
    end
endmodule

// File: rtl/mant_align.sv
// Alignment stage: right-shifts the smaller operand's mantissa by shamt, SH_STEP bits per cycle.
module mant_align #(
    parameter int unsigned MANT_W  = mant_align_pkg::MANT_W,
    parameter int unsigned EXP_W   = mant_align_pkg::EXP_W,
    parameter int unsigned SH_STEP = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    mant_align_if.slave  bus
);
    import mant_align_pkg::*;

    localparam int unsigned W = MANT_W + GRS_W;

    state_t          state_q;
    logic [W-1:0]    ma_q, mb_q;
    logic [W-1:0]    sh_src, sh_d;
    logic [EXP_W-1:0] e_q;
    logic [4:0]      rem_q, rem_in, k;
    logic            sel_q, out_valid_q, accept;

    always_comb begin
        k      = (rem_q > 5'(SH_STEP)) ? 5'(SH_STEP) : rem_q;
        rem_in = (bus.shamt > 5'(SHAMT_MAX)) ? 5'(SHAMT_MAX) : bus.shamt;
        sh_src = sel_q ? mb_q : ma_q;
    end

    // Held low during reset even though the state register already reads IDLE.
    assign bus.in_ready = rst_n && ((state_q == IDLE) || (state_q == DONE && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;

    sticky_shr #(.W(W), .KW(5)) u_shr (
        .val_i (sh_src),
        .k_i   (k),
        .val_o (sh_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ma_q        <= '0;
            mb_q        <= '0;
            e_q         <= '0;
            rem_q       <= '0;
            sel_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            // Accept wins over DONE handoff so a result and a new set can swap in one cycle.
            ma_q  <= {bus.m_a, {GRS_W{1'b0}}};
            mb_q  <= {bus.m_b, {GRS_W{1'b0}}};
            e_q   <= bus.sh_ab ? bus.e_a : bus.e_b;
            rem_q <= rem_in;
            sel_q <= bus.sh_ab;
            if (rem_in == '0) begin
                state_q     <= DONE;
                out_valid_q <= 1'b1;
            end else begin
                state_q     <= SHIFT;
                out_valid_q <= 1'b0;
            end
        end else begin
            case (state_q)
                SHIFT: begin
                    if (sel_q) mb_q <= sh_d;
                    else       ma_q <= sh_d;
                    rem_q <= rem_q - k;
                    if (rem_q == k) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.ma_out    = ma_q;
    assign bus.mb_out    = mb_q;
    assign bus.e_out     = e_q;
endmodule
